i2c_bus_frontend: RTL

I2C_BUS_FRONTEND -- requirements
Module: i2c_bus_frontend

---
 rtl/i2c_bus_frontend.sv | 133 +++++++++++++
 1 files changed

// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend
//   Conditions the raw SCL/SDA pad levels of an I2C bus: each line passes
//   through a synchroniser chain and a glitch filter.  The filtered levels
//   drive SCL edge detection, START/STOP detection and a bus-busy flag.
//   Every output is registered.
//
// Parameters
//   SYNC_STAGES  synchroniser flops per line (2..4)
//   FILTER_LEN   consecutive differing samples needed to accept a level change (1..15)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   scl_i       raw asynchronous SCL pad level
//   sda_i       raw asynchronous SDA pad level
//   scl_o       filtered SCL level
//   sda_o       filtered SDA level
//   scl_rise_o  one-cycle pulse when scl_o goes 0->1
//   scl_fall_o  one-cycle pulse when scl_o goes 1->0
//   start_o     one-cycle pulse on START / repeated START
//   stop_o      one-cycle pulse on STOP
//   busy_o      bus held between START and STOP
module i2c_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic busy_o
);

    // Line index 0 is SCL, 1 is SDA; both lines share the same logic.
    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic [1:0]                  pad;
    logic [1:0][SYNC_STAGES-1:0] sync;
    logic [1:0][3:0]             cnt;
    logic [1:0][3:0]             cnt_next;
    logic [1:0]                  filt;
    logic [1:0]                  filt_next;
    state_t                      state;
    state_t                      state_next;

    assign pad = {sda_i, scl_i};

    // Synchronisers, filter counters and filtered levels; reset to idle bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync <= '1;
            cnt  <= '0;
            filt <= '1;
        end else begin
            for (int unsigned l = 0; l < 2; l++) begin
                sync[l] <= {sync[l][SYNC_STAGES-2:0], pad[l]};
            end
            cnt  <= cnt_next;
            filt <= filt_next;
        end
    end

    // Counter runs only while the synchronised level disagrees with the
    // filtered one; the level flips once it has disagreed FILTER_LEN times.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            if (sync[l][SYNC_STAGES-1] != filt[l]) begin
                if (cnt[l] == CNT_MAX) begin
                    filt_next[l] = ~filt[l];
                end else begin
                    cnt_next[l] = cnt[l] + 4'd1;
                end
            end
        end
    end

    assign scl_o = filt[0];
    assign sda_o = filt[1];

    // Pulses are computed from the next filtered levels so they register in
    // the same cycle the new level first appears on scl_o/sda_o.  START/STOP
    // require SCL high both before and after, which also suppresses them
    // when SCL and SDA flip together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_rise_o <= filt_next[0] & ~filt[0];
            scl_fall_o <= ~filt_next[0] & filt[0];
            start_o    <= filt[0] & filt_next[0] & filt[1] & ~filt_next[1];
            stop_o     <= filt[0] & filt_next[0] & ~filt[1] & filt_next[1];
        end
    end

    // Bus ownership state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_o) state_next = BUSY;
            BUSY:    if (stop_o)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == BUSY);
    end

endmodule
